// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiplies skip CALC.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [5:0]       select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO2    = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (ZERO - v) : v;
  endfunction

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 neg_q_r;
  logic                 neg_rem_r;
  logic                 special_r;
  logic [WIDTH-1:0]     spec_val_r;

  logic [2:0]           op_s;
  logic                 a_signed_s;
  logic                 b_signed_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic                 div0_s;
  logic                 ovf_s;
  logic                 mzero_s;
  logic                 special_s;
  logic                 early_s;
  logic                 accept_s;
  logic [WIDTH-1:0]     spec_val_s;
  logic [WIDTH-1:0]     mag1_s;
  logic [WIDTH-1:0]     mag2_s;

  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       rem_sh_s;
  logic [WIDTH:0]       diff_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [2*WIDTH-1:0]   div_next_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     fix_s;

  // Request decode: operand signedness, magnitudes and the special-case result.
  always_comb begin
    op_s       = select[2:0];
    accept_s   = start && (select[5:3] == 3'b001);
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op_s)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s   = a_signed_s && data1[WIDTH-1];
    b_neg_s   = b_signed_s && data2[WIDTH-1];
    mag1_s    = cond_neg(data1, a_neg_s);
    mag2_s    = cond_neg(data2, b_neg_s);
    div0_s    = op_s[2] && (data2 == ZERO);
    ovf_s     = ((op_s == OP_DIV) || (op_s == OP_REM)) && (data1 == MIN_NEG) && (data2 == ONES);
    mzero_s   = !op_s[2] && ((data1 == ZERO) || (data2 == ZERO));
    special_s = div0_s || ovf_s || mzero_s;
    if (div0_s) begin
      spec_val_s = op_s[1] ? data1 : ONES;
    end else if (ovf_s) begin
      spec_val_s = op_s[1] ? ZERO : MIN_NEG;
    end else begin
      spec_val_s = ZERO;
    end
`ifdef MULDIV_EARLY_OUT_EN
    early_s = special_s;
`else
    early_s = 1'b0;
`endif
  end

  // One iteration of shift-add multiply and restoring divide on the shared accumulator.
  always_comb begin
    add_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, a_r};
    if (acc_r[0]) begin
      mul_next_s = {add_s, acc_r[WIDTH-1:1]};
    end else begin
      mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end
    // Remainder lives in the upper half, dividend/quotient shifts through the lower half.
    rem_sh_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, b_r};
    if (!diff_s[WIDTH]) begin
      div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup and result selection applied in the finishing cycle.
  always_comb begin
    prod_s = neg_q_r ? (ZERO2 - acc_r) : acc_r;
    quo_s  = cond_neg(acc_r[WIDTH-1:0], neg_q_r);
    rem_s  = cond_neg(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
    case (op_r)
      OP_MUL:                       fix_s = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_s = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_s = quo_s;
      OP_REM, OP_REMU:              fix_s = rem_s;
      default:                      fix_s = ZERO;
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      op_r       <= 3'b000;
      a_r        <= ZERO;
      b_r        <= ZERO;
      acc_r      <= ZERO2;
      neg_q_r    <= 1'b0;
      neg_rem_r  <= 1'b0;
      special_r  <= 1'b0;
      spec_val_r <= ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= ZERO;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r       <= op_s;
            a_r        <= mag1_s;
            b_r        <= mag2_s;
            acc_r      <= op_s[2] ? {ZERO, mag1_s} : {ZERO, mag2_s};
            neg_q_r    <= a_neg_s ^ b_neg_s;
            neg_rem_r  <= a_neg_s;
            special_r  <= special_s;
            spec_val_r <= spec_val_s;
            cnt_r      <= CNT_LAST;
            busy       <= 1'b1;
            state_r    <= early_s ? S_FIN : S_CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_r <= op_r[2] ? div_next_s : mul_next_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ZERO) begin
            state_r <= S_FIN;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIN: begin
          result  <= special_r ? spec_val_r : fix_s;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
